// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   MEM stage of a 64-bit in-order pipeline. Turns the EX/MEM load/store
//   request into a single outstanding memory transaction, stalls the front of
//   the pipeline until the memory completes, extends load data by size/sign,
//   and registers the MEM/WB pipeline outputs.
//
// Build option:
//   MEM_MISALIGN_TRAP_EN - when defined, an access whose byte lane is not
//   aligned to its size issues no memory request. It passes through as a
//   non-memory instruction with RegWrite3=0 and ReadData3=0, and misalign_o
//   pulses for one cycle. When undefined, the low lane bits below the access
//   size are ignored and misalign_o does not exist.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ALUResult2            EX/MEM effective address / ALU result
//   ReadData2out          EX/MEM store data (rs2)
//   MemRead2, MemWrite2   EX/MEM load / store request (both high = store)
//   MemtoReg2, RegWrite2  EX/MEM writeback controls
//   Rd2                   EX/MEM destination register
//   EX_MEM_funct3         size/sign: 000 b, 001 h, 010 w, 011 d,
//                         100 bu, 101 hu, 110 wu, 111 treated as d
//   mem_req, mem_we       memory request / store select
//   mem_addr              doubleword-aligned address
//   mem_wdata, mem_wstrb  store data on its byte lanes and byte enables
//   mem_rdata, mem_ack    load data and one-cycle completion pulse
//   stall                 combinational pipeline freeze
//   ReadData3, ALUResult3, MemtoReg3, RegWrite3, Rd3   MEM/WB outputs
//   misalign_o            (MEM_MISALIGN_TRAP_EN only) misaligned-access pulse
//   o_dbg_state           FSM state: 0 IDLE, 1 BUSY, 2 DONE
// -----------------------------------------------------------------------------
module mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] ALUResult2,
   input  logic [63:0] ReadData2out,
   input  logic        MemRead2,
   input  logic        MemWrite2,
   input  logic        MemtoReg2,
   input  logic        RegWrite2,
   input  logic [4:0]  Rd2,
   input  logic [2:0]  EX_MEM_funct3,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wstrb,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic [63:0] ReadData3,
   output logic [63:0] ALUResult3,
   output logic        MemtoReg3,
   output logic        RegWrite3,
   output logic [4:0]  Rd3,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic        misalign_o,
`endif
   output logic [1:0]  o_dbg_state
);

   // Memory handshake: mem_req is the valid. Once raised, mem_req, mem_we,
   // mem_addr, mem_wdata and mem_wstrb stay stable until the memory returns a
   // single-cycle mem_ack, which acts as ready and completion at once. Only
   // one transaction is ever outstanding; an ack outside BUSY is ignored.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        w_stall;

   // Request registers
   logic        r_mem_req;
   logic        r_mem_we;
   logic [63:0] r_mem_addr;
   logic [63:0] r_mem_wdata;
   logic [7:0]  r_mem_wstrb;

   // Access attributes kept for the load extension at ack time
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [2:0]  r_lane;
   logic [63:0] r_load_data;

   // MEM/WB registers
   logic [63:0] r_read_data3;
   logic [63:0] r_alu_result3;
   logic        r_mem_to_reg3;
   logic        r_reg_write3;
   logic [4:0]  r_rd3;

   // Decode of the incoming EX/MEM access
   logic        w_raw_access;
   logic        w_access;
   logic        w_trap;
   logic [1:0]  w_size;        // 0 byte, 1 half, 2 word, 3 double
   logic        w_unsigned;
   logic [2:0]  w_lane_aligned;
   logic [7:0]  w_size_mask;
   logic [63:0] w_byte_mask;
   logic [7:0]  w_wstrb;
   logic [63:0] w_wdata;

   // Load path
   logic [63:0] w_rdata_shifted;
   logic [63:0] w_load_ext;

   // ---------------------------------------------------------------------------
   // Access decode
   // ---------------------------------------------------------------------------
   always_comb begin
      w_size     = 2'd3;
      w_unsigned = 1'b0;
      case (EX_MEM_funct3)
         3'b000: begin w_size = 2'd0; w_unsigned = 1'b0; end
         3'b001: begin w_size = 2'd1; w_unsigned = 1'b0; end
         3'b010: begin w_size = 2'd2; w_unsigned = 1'b0; end
         3'b011: begin w_size = 2'd3; w_unsigned = 1'b0; end
         3'b100: begin w_size = 2'd0; w_unsigned = 1'b1; end
         3'b101: begin w_size = 2'd1; w_unsigned = 1'b1; end
         3'b110: begin w_size = 2'd2; w_unsigned = 1'b1; end
         default: begin w_size = 2'd3; w_unsigned = 1'b0; end // 111 acts as d
      endcase
   end

   // Lane bits below the access size are dropped so every access stays
   // inside one doubleword.
   always_comb begin
      w_lane_aligned = ALUResult2[2:0];
      w_size_mask    = 8'hFF;
      case (w_size)
         2'd0: begin
            w_lane_aligned = ALUResult2[2:0];
            w_size_mask    = 8'h01;
         end
         2'd1: begin
            w_lane_aligned = {ALUResult2[2:1], 1'b0};
            w_size_mask    = 8'h03;
         end
         2'd2: begin
            w_lane_aligned = {ALUResult2[2], 2'b00};
            w_size_mask    = 8'h0F;
         end
         default: begin
            w_lane_aligned = 3'b000;
            w_size_mask    = 8'hFF;
         end
      endcase
   end

   always_comb begin
      w_byte_mask = '0;
      for (int i = 0; i < 8; i++) begin
         w_byte_mask[8*i +: 8] = {8{w_size_mask[i]}};
      end
   end

   // Store data is trimmed to its size before moving to the lane, so bytes
   // outside the strobe are always zero on the bus.
   assign w_wstrb = w_size_mask << w_lane_aligned;
   assign w_wdata = (ReadData2out & w_byte_mask) << {w_lane_aligned, 3'b000};

   assign w_raw_access = MemRead2 | MemWrite2;

`ifdef MEM_MISALIGN_TRAP_EN
   logic w_misalign;
   assign w_misalign = (ALUResult2[2:0] != w_lane_aligned);
   assign w_trap     = w_raw_access & w_misalign;
`else
   assign w_trap     = 1'b0;
`endif

   // A trapped access is handled exactly like a non-memory instruction.
   assign w_access = w_raw_access & ~w_trap;

   // ---------------------------------------------------------------------------
   // Load extension, using the attributes latched when the request issued
   // ---------------------------------------------------------------------------
   assign w_rdata_shifted = mem_rdata >> {r_lane, 3'b000};

   always_comb begin
      w_load_ext = w_rdata_shifted;
      case (r_size)
         2'd0: w_load_ext = r_unsigned ? {56'd0, w_rdata_shifted[7:0]}
                                       : {{56{w_rdata_shifted[7]}}, w_rdata_shifted[7:0]};
         2'd1: w_load_ext = r_unsigned ? {48'd0, w_rdata_shifted[15:0]}
                                       : {{48{w_rdata_shifted[15]}}, w_rdata_shifted[15:0]};
         2'd2: w_load_ext = r_unsigned ? {32'd0, w_rdata_shifted[31:0]}
                                       : {{32{w_rdata_shifted[31]}}, w_rdata_shifted[31:0]};
         default: w_load_ext = w_rdata_shifted;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // DONE drops stall for one cycle so the held instruction leaves EX/MEM;
   // going straight back to IDLE with it still present would re-issue it.
   always_comb begin
      w_next_state = r_state;
      w_stall      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_access) begin
               w_next_state = S_BUSY;
               w_stall      = 1'b1;
            end
         end
         S_BUSY: begin
            w_stall = 1'b1;
            if (mem_ack) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
      if (reset) begin
         w_stall = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Request, load capture and MEM/WB registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_mem_wstrb   <= '0;
         r_size        <= '0;
         r_unsigned    <= 1'b0;
         r_lane        <= '0;
         r_load_data   <= '0;
         r_read_data3  <= '0;
         r_alu_result3 <= '0;
         r_mem_to_reg3 <= 1'b0;
         r_reg_write3  <= 1'b0;
         r_rd3         <= '0;
      end else begin
         if ((r_state == S_IDLE) && w_access) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= MemWrite2;      // store wins when both are set
            r_mem_addr  <= {ALUResult2[63:3], 3'b000};
            r_mem_wdata <= MemWrite2 ? w_wdata : 64'd0;
            r_mem_wstrb <= MemWrite2 ? w_wstrb : 8'd0;
            r_size      <= w_size;
            r_unsigned  <= w_unsigned;
            r_lane      <= w_lane_aligned;
         end

         if ((r_state == S_BUSY) && mem_ack) begin
            r_mem_req   <= 1'b0;
            r_load_data <= r_mem_we ? 64'd0 : w_load_ext;
         end

         // Only the DONE cycle carries load data; stores and non-memory
         // instructions write zero.
         if (!w_stall) begin
            r_read_data3  <= (r_state == S_DONE) ? r_load_data : 64'd0;
            r_alu_result3 <= ALUResult2;
            r_mem_to_reg3 <= MemtoReg2;
            r_reg_write3  <= RegWrite2 & ~w_trap;
            r_rd3         <= Rd2;
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic r_misalign;

   // Rises together with the MEM/WB update of the trapped instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_trap && (r_state == S_IDLE);
      end
   end

   assign misalign_o = r_misalign;
`endif

   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign mem_wstrb   = r_mem_wstrb;
   assign stall       = w_stall;
   assign ReadData3   = r_read_data3;
   assign ALUResult3  = r_alu_result3;
   assign MemtoReg3   = r_mem_to_reg3;
   assign RegWrite3   = r_reg_write3;
   assign Rd3         = r_rd3;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. A responder process answers memory
// requests after a programmable delay. Each instruction pushes its expected
// MEM/WB result into exp_q when driven; the result is popped and compared on
// the edge where the pipeline advances. Works with or without
// MEM_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int WB_W = 135;   // {ReadData3, ALUResult3, MemtoReg3, RegWrite3, Rd3}

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [63:0] ALUResult2;
   logic [63:0] ReadData2out;
   logic        MemRead2;
   logic        MemWrite2;
   logic        MemtoReg2;
   logic        RegWrite2;
   logic [4:0]  Rd2;
   logic [2:0]  EX_MEM_funct3;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic [63:0] mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic [63:0] ReadData3;
   logic [63:0] ALUResult3;
   logic        MemtoReg3;
   logic        RegWrite3;
   logic [4:0]  Rd3;
   logic [1:0]  dbg_state;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   mem_access_unit dut (
      .clk           (clk),
      .reset         (reset),
      .ALUResult2    (ALUResult2),
      .ReadData2out  (ReadData2out),
      .MemRead2      (MemRead2),
      .MemWrite2     (MemWrite2),
      .MemtoReg2     (MemtoReg2),
      .RegWrite2     (RegWrite2),
      .Rd2           (Rd2),
      .EX_MEM_funct3 (EX_MEM_funct3),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack),
      .stall         (stall),
      .ReadData3     (ReadData3),
      .ALUResult3    (ALUResult3),
      .MemtoReg3     (MemtoReg3),
      .RegWrite3     (RegWrite3),
      .Rd3           (Rd3),
`ifdef MEM_MISALIGN_TRAP_EN
      .misalign_o    (misalign_o),
`endif
      .o_dbg_state   (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Memory responder: auto ack after resp_delay request cycles, plus a
   // separately driven stray ack for the ignore tests.
   // ---------------------------------------------------------------------------
   logic        auto_ack   = 1'b0;
   logic [63:0] auto_rdata = '0;
   logic        spur_ack   = 1'b0;
   logic [63:0] spur_rdata = '0;
   logic        resp_en    = 1'b1;
   int          resp_delay = 1;
   logic [63:0] resp_data  = '0;
   int          resp_cnt   = 0;

   assign mem_ack   = auto_ack | spur_ack;
   assign mem_rdata = spur_ack ? spur_rdata : auto_rdata;

   initial begin : responder
      forever begin
         @(posedge clk);
         #1;
         auto_ack = 1'b0;
         if (mem_req && resp_en) begin
            resp_cnt++;
            if (resp_cnt >= resp_delay) begin
               auto_ack   = 1'b1;
               auto_rdata = resp_data;
               resp_cnt   = 0;
            end
         end else begin
            resp_cnt = 0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [WB_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [WB_W-1:0] got,
                            input logic [WB_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WB_W-1:0] pack_wb(input logic [63:0] rdat, input logic [63:0] alu,
                                               input logic mtr, input logic rw,
                                               input logic [4:0] rd);
      return {rdat, alu, mtr, rw, rd};
   endfunction

   function automatic logic [WB_W-1:0] dut_wb();
      return {ReadData3, ALUResult3, MemtoReg3, RegWrite3, Rd3};
   endfunction

   function automatic int size_bytes(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010, 3'b110: return 4;
         default:        return 8;
      endcase
   endfunction

   // Byte-by-byte reference for load extraction and extension.
   function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [2:0] lo,
                                              input logic [2:0] f3);
      int n;
      int lane;
      logic [63:0] v;
      n    = size_bytes(f3);
      lane = int'(lo) - (int'(lo) % n);
      v    = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(lane+i) +: 8];
      if (f3[2] == 1'b0 && n < 8 && v[8*n-1] == 1'b1) begin
         for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      end
      return v;
   endfunction

   task automatic drive_bubble();
      ALUResult2    = '0;
      ReadData2out  = '0;
      MemRead2      = 1'b0;
      MemWrite2     = 1'b0;
      MemtoReg2     = 1'b0;
      RegWrite2     = 1'b0;
      Rd2           = '0;
      EX_MEM_funct3 = '0;
   endtask

   // Drives one instruction (call at posedge+1), waits for the advancing edge,
   // compares MEM/WB, then leaves a bubble on EX/MEM.
   task automatic issue(input string tag, input logic [63:0] alu, input logic [63:0] rs2,
                        input logic rd_en, input logic wr_en, input logic mtr,
                        input logic rw, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [WB_W-1:0] exp,
                        output int cycles, output int stall_cyc, output logic saw_req,
                        output logic [63:0] req_addr, output logic [63:0] req_wdata,
                        output logic [7:0] req_wstrb, output logic req_we);
      logic done;
      logic hold_bad;
      ALUResult2    = alu;
      ReadData2out  = rs2;
      MemRead2      = rd_en;
      MemWrite2     = wr_en;
      MemtoReg2     = mtr;
      RegWrite2     = rw;
      Rd2           = rd;
      EX_MEM_funct3 = f3;
      exp_q.push_back(exp);
      cycles    = 0;
      stall_cyc = 0;
      saw_req   = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      req_we    = 1'b0;
      done      = 1'b0;
      hold_bad  = 1'b0;
      while (!done && cycles < 60) begin
         @(negedge clk);
         cycles++;
         if (mem_req) begin
            if (!saw_req) begin
               req_addr  = mem_addr;
               req_wdata = mem_wdata;
               req_wstrb = mem_wstrb;
               req_we    = mem_we;
            end else if (mem_addr !== req_addr || mem_wdata !== req_wdata ||
                         mem_wstrb !== req_wstrb || mem_we !== req_we) begin
               hold_bad = 1'b1;
            end
            saw_req = 1'b1;
         end
         if (stall) stall_cyc++;
         else done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
         check_val({tag, "_timeout"}, WB_W'(1), WB_W'(0));
         void'(exp_q.pop_front());
      end else begin
         check_val({tag, "_wb"}, dut_wb(), exp_q.pop_front());
      end
      if (saw_req) check_val({tag, "_hold"}, WB_W'(hold_bad), WB_W'(0));
      drive_bubble();
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   int          cyc;
   int          stl;
   logic        sreq;
   logic [63:0] raddr;
   logic [63:0] rwdata;
   logic [7:0]  rwstrb;
   logic        rwe;

   initial begin : main
      logic [2:0]  f3;
      int          n;
      int          lane;
      logic [63:0] alu;
      logic [63:0] rdata;

      drive_bubble();
      reset = 1'b1;
      // A pending load during reset must neither stall nor issue.
      MemRead2 = 1'b1;
      ALUResult2 = 64'h1000;
      EX_MEM_funct3 = 3'b011;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_stall", WB_W'(stall), WB_W'(0));
      check_val("rst_req", WB_W'(mem_req), WB_W'(0));
      check_val("rst_state", WB_W'(dbg_state), WB_W'(0));
      check_val("rst_bus", WB_W'({mem_we, mem_addr, mem_wdata, mem_wstrb}), WB_W'(0));
      check_val("rst_wb", dut_wb(), WB_W'(0));
      @(posedge clk);
      #1;
      drive_bubble();
      reset = 1'b0;
      @(posedge clk);
      #1;

      // ld 0x1000, ack in the third BUSY cycle
      resp_delay = 3;
      resp_data  = 64'h1122334455667788;
      issue("ld", 64'h1000, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 3'b011,
            pack_wb(64'h1122334455667788, 64'h1000, 1'b1, 1'b1, 5'd5),
            cyc, stl, sreq, raddr, rwdata, rwstrb, rwe);
      check_val("ld_stall_cycles", WB_W'(stl), WB_W'(4));
      check_val("ld_addr", WB_W'(raddr), WB_W'(64'h1000));
      check_val("ld_we_wstrb", WB_W'({rwe, rwstrb}), WB_W'(0));
      check_val("ld_req_seen", WB_W'(sreq), WB_W'(1));

      // lb / lbu at 0x1003 with zero-wait memory: 3-cycle latency
      resp_delay = 1;
      resp_data  = 64'h00000000F0000000;
      issue("lb", 64'h1003, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 3'b000,
            pack_wb(64'hFFFFFFFFFFFFFFF0, 64'h1003, 1'b1, 1'b1, 5'd6),
            cyc, stl, sreq, raddr, rwdata, rwstrb, rwe);
      check_val("lb_latency", WB_W'(cyc), WB_W'(3));
      check_val("lb_stall_cycles", WB_W'(stl), WB_W'(2));
      check_val("lb_addr", WB_W'(raddr), WB_W'(64'h1000));
      issue("lbu", 64'h1003, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 3'b100,
            pack_wb(64'h00000000000000F0, 64'h1003, 1'b1, 1'b1, 5'd6),
            cyc, stl, sreq, raddr, rwdata, rwstrb, rwe);

      // sh 0x2006
      resp_delay = 2;
      issue("sh", 64'h2006, 64'h000000000000ABCD, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 3'b001,
            pack_wb(64'h0, 64'h2006, 1'b0, 1'b0, 5'd0),
            cyc, stl, sreq, raddr, rwdata, rwstrb, rwe);
      check_val("sh_addr", WB_W'(raddr), WB_W'(64'h2000));
      check_val("sh_wstrb", WB_W'(rwstrb), WB_W'(8'hC0));
      check_val("sh_wdata", WB_W'(rwdata), WB_W'(64'hABCD000000000000));
      check_val("sh_we", WB_W'(rwe), WB_W'(1));

      // Read and write both set: store wins, upper rs2 bytes dropped
      resp_delay = 1;
      issue("sw_rw", 64'h4004, 64'h12345678DEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 3'b010,
            pack_wb(64'h0, 64'h4004, 1'b1, 1'b1, 5'd9),
            cyc, stl, sreq, raddr, rwdata, rwstrb, rwe);
      check_val("sw_rw_we", WB_W'(rwe), WB_W'(1));
      check_val("sw_rw_wstrb", WB_W'(rwstrb), WB_W'(8'hF0));
      check_val("sw_rw_wdata", WB_W'(rwdata), WB_W'(64'hDEADBEEF00000000));

      // funct3 111 behaves as a doubleword load
      resp_data = 64'h8000000000000001;
      issue("ld_f7", 64'h5000, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 3'b111,
            pack_wb(64'h8000000000000001, 64'h5000, 1'b1, 1'b1, 5'd11),
            cyc, stl, sreq, raddr, rwdata, rwstrb, rwe);

      // Stray ack in IDLE
      @(negedge clk);
      spur_ack   = 1'b1;
      spur_rdata = 64'hDEADDEADDEADDEAD;
      @(posedge clk);
      #1;
      spur_ack = 1'b0;
      @(negedge clk);
      check_val("spur_state", WB_W'(dbg_state), WB_W'(0));
      check_val("spur_req_stall", WB_W'({mem_req, stall}), WB_W'(0));
      check_val("spur_wb", dut_wb(), WB_W'(0));
      @(posedge clk);
      #1;

      // Back-to-back adds
      issue("add1", 64'h55, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 3'b000,
            pack_wb(64'h0, 64'h55, 1'b0, 1'b1, 5'd7),
            cyc, stl, sreq, raddr, rwdata, rwstrb, rwe);
      check_val("add1_latency", WB_W'({cyc, stl}), WB_W'({32'd1, 32'd0}));
      issue("add2", 64'h66, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 3'b000,
            pack_wb(64'h0, 64'h66, 1'b0, 1'b1, 5'd8),
            cyc, stl, sreq, raddr, rwdata, rwstrb, rwe);
      check_val("add2_latency", WB_W'({cyc, stl, 31'd0, sreq}), WB_W'({32'd1, 32'd0, 32'd0}));

      // Random aligned loads of every size
      for (int k = 0; k < 6; k++) begin
         f3         = 3'($urandom_range(0, 7));
         n          = size_bytes(f3);
         lane       = $urandom_range(0, 7);
         lane       = lane - (lane % n);
         alu        = 64'h7000 + 64'(k * 8) + 64'(lane);
         rdata      = {$urandom, $urandom};
         resp_data  = rdata;
         resp_delay = $urandom_range(1, 3);
         issue("rnd_load", alu, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'(k + 12), f3,
               pack_wb(model_load(rdata, alu[2:0], f3), alu, 1'b1, 1'b1, 5'(k + 12)),
               cyc, stl, sreq, raddr, rwdata, rwstrb, rwe);
         check_val("rnd_addr", WB_W'(raddr), WB_W'({alu[63:3], 3'b000}));
      end

      // Reset in the second BUSY cycle, then a late ack
      resp_en       = 1'b0;
      ALUResult2    = 64'h6000;
      MemRead2      = 1'b1;
      MemtoReg2     = 1'b1;
      RegWrite2     = 1'b1;
      Rd2           = 5'd3;
      EX_MEM_funct3 = 3'b011;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val("abort_busy", WB_W'({dbg_state, mem_req}), WB_W'({2'd1, 1'b1}));
      reset = 1'b1;
      drive_bubble();
      @(posedge clk);
      #1;
      reset      = 1'b0;
      spur_ack   = 1'b1;
      spur_rdata = 64'hFFFFFFFFFFFFFFFF;
      @(negedge clk);
      check_val("abort_state", WB_W'({dbg_state, mem_req, stall}), WB_W'(0));
      check_val("abort_bus", WB_W'({mem_we, mem_addr, mem_wdata, mem_wstrb}), WB_W'(0));
      check_val("abort_wb", dut_wb(), WB_W'(0));
      @(posedge clk);
      #1;
      spur_ack = 1'b0;
      @(negedge clk);
      check_val("abort_after_ack", WB_W'({dbg_state, mem_req}), WB_W'(0));
      check_val("abort_wb2", dut_wb(), WB_W'(0));
      resp_en = 1'b1;
      @(posedge clk);
      #1;

      // lw at 0x3002
`ifdef MEM_MISALIGN_TRAP_EN
      issue("lw_mis", 64'h3002, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 3'b010,
            pack_wb(64'h0, 64'h3002, 1'b1, 1'b0, 5'd4),
            cyc, stl, sreq, raddr, rwdata, rwstrb, rwe);
      check_val("lw_mis_noreq", WB_W'({sreq, stl}), WB_W'(0));
      check_val("lw_mis_pulse", WB_W'(misalign_o), WB_W'(1));
      @(posedge clk);
      #1;
      check_val("lw_mis_pulse_end", WB_W'(misalign_o), WB_W'(0));
`else
      resp_delay = 1;
      resp_data  = 64'hCAFEBABE87654321;
      issue("lw_mis", 64'h3002, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 3'b010,
            pack_wb(64'hFFFFFFFF87654321, 64'h3002, 1'b1, 1'b1, 5'd4),
            cyc, stl, sreq, raddr, rwdata, rwstrb, rwe);
      check_val("lw_mis_addr", WB_W'(raddr), WB_W'(64'h3000));
      check_val("lw_mis_req", WB_W'(sreq), WB_W'(1));
`endif

      check_val("queue_empty", WB_W'(exp_q.size()), WB_W'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      n_checks++;
      n_errors++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit
Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 ALUResult2  in  64  EX/MEM effective address / ALU result.
REQ-004 ReadData2out  in  64  EX/MEM store data (rs2).
REQ-005 MemRead2  in  1  EX/MEM load request.
REQ-006 MemWrite2  in  1  EX/MEM store request.
REQ-007 MemtoReg2  in  1  EX/MEM writeback select.
REQ-008 RegWrite2  in  1  EX/MEM register write enable.
REQ-009 Rd2  in  5  EX/MEM destination register.
REQ-010 EX_MEM_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-011 mem_req  out  1  registered memory request; held until ack.
REQ-012 mem_we  out  1  1 = store, 0 = load; valid while mem_req.
REQ-013 mem_addr  out  64  doubleword-aligned address: ALUResult2 with bits [2:0] forced to 0.
REQ-014 mem_wdata  out  64  store data shifted to its byte lane.
REQ-015 mem_wstrb  out  8  byte enables; 0 for loads.
REQ-016 mem_rdata  in  64  load data; valid in the cycle mem_ack=1.
REQ-017 mem_ack  in  1  memory completion, one-cycle pulse.
REQ-018 stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-019 ReadData3  out  64  MEM/WB load data, extended per funct3.
REQ-020 ALUResult3  out  64  MEM/WB ALU result.
REQ-021 MemtoReg3, RegWrite3  out  1 each  MEM/WB control.
REQ-022 Rd3  out  5  MEM/WB destination.
Function
REQ-023 FSM states IDLE, BUSY, DONE; access = MemRead2|MemWrite2.
REQ-024 IDLE: access=1 -> BUSY; mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb registered on the same edge; stall=1 in this cycle.
REQ-025 BUSY: stall=1; all mem_* outputs held stable; mem_ack=1 -> capture extended load data, drop mem_req, go to DONE.
REQ-026 DONE: stall=0 for exactly one cycle, which lets the pipeline advance; -> IDLE next edge. This prevents re-issue of the held instruction.
REQ-027 MEM/WB outputs load from EX/MEM inputs on every edge where stall=0; otherwise they hold.
REQ-028 Non-memory instructions pass through with 1-cycle latency and no stall.
REQ-029 Latency with zero-wait memory (ack in first BUSY cycle): access seen cycle 0, MEM/WB updated at end of cycle 2.
REQ-030 Byte lane = ALUResult2[2:0]; wstrb = size mask << lane. wdata = rs2 low bytes << 8*lane.
REQ-031 Load: select bytes from lane. Sign-extend for b/h/w; zero-extend for bu/hu/wu. d uses all 64 bits.
REQ-032 For a store, ReadData3 = 0.
REQ-033 MemRead2 and MemWrite2 both high: the access is a store; the read is ignored.
REQ-034 Undefined funct3 (111) is treated as d.
REQ-035 mem_ack outside BUSY is ignored.
Reset
REQ-036 reset=1: state to IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, ReadData3, ALUResult3, MemtoReg3, RegWrite3, Rd3 cleared to 0; stall=0.
REQ-037 reset during BUSY aborts the access; a later ack is ignored per REQ-035.
Configuration
REQ-038 With MEM_MISALIGN_TRAP_EN defined: an access whose lane is not size-aligned issues no request, passes through as a non-memory instruction with RegWrite3=0 and ReadData3=0, and raises output misalign_o for 1 cycle. Without the macro: lane bits below the size are ignored (forced aligned), and the misalign_o port is absent.
Verification
REQ-039 Bench covers: ld with addr 0x1000, ack after 3 cycles with rdata 0x1122334455667788 -> stall high for 4 cycles, ReadData3=0x1122334455667788, Rd3 as given.
REQ-040 Bench covers: lb with addr 0x1003, rdata 0x00000000F0000000 -> ReadData3=0xFFFFFFFFFFFFFFF0; the same access as lbu -> 0xF0.
REQ-041 Bench covers: sh with addr 0x2006, rs2 0xABCD -> mem_wstrb=0xC0, mem_wdata=0xABCD000000000000, mem_addr=0x2000, ReadData3=0.
REQ-042 Bench covers: back-to-back add, add -> no stall, MEM/WB follows 1 cycle behind; a spurious mem_ack in IDLE has no effect.
REQ-043 Bench covers: reset asserted in second BUSY cycle, then ack -> mem_req=0, all outputs 0, state IDLE, no MEM/WB update.
REQ-044 Bench covers: lw at 0x3002 -> with MEM_MISALIGN_TRAP_EN: no mem_req, RegWrite3=0, misalign_o pulses; without the macro: mem_addr=0x3000, word taken from lane 0.
